mem_access_unit: RTL and testbench

Multi-cycle data-memory stage sitting directly downstream of the ALU: it takes the ALU `result` as a byte address together with the store data and load/store controls, and performs one byte, halfword or word access against an internal little-endian RAM with a fixed number of wait states. While an access is in flight it raises `Busy` so the control unit can stall the PC. On completion it pulses `Done`, presenting load data or an alignment fault.

---
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Multi-cycle data-memory stage fed by the ALU result. Performs one byte,
//   halfword or word access against an internal little-endian RAM with a fixed
//   number of wait states, stalling the core via Busy and pulsing Done at the end.
//
// Parameters
//   DEPTH_BYTES  RAM size in bytes (power of two, >= 4)
//   WAIT_STATES  extra cycles per access (0..15)
//
// Ports
//   CLK        clock, rising edge
//   nReset     asynchronous active-low reset
//   Start      request strobe, sampled only while idle
//   MemRead    load request
//   MemWrite   store request
//   Size       00 byte, 01 halfword, 10/11 word
//   SignExt    loads: 1 sign-extend, 0 zero-extend (ignored for words)
//   Address    byte address; wraps modulo DEPTH_BYTES
//   WriteData  store data, low byte/half used for narrow stores
//   ReadData   load result, held until the next successful load
//   Busy       access in progress
//   Done       one-cycle completion pulse
//   AlignErr   qualifies Done: access was misaligned and not performed
module mem_access_unit #(
   parameter int unsigned DEPTH_BYTES = 256,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        CLK,
   input  logic        nReset,
   input  logic        Start,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  Size,
   input  logic        SignExt,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Busy,
   output logic        Done,
   output logic        AlignErr
);

   localparam int unsigned AW = $clog2(DEPTH_BYTES);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t      state;
   state_t      state_n;
   logic [3:0]  cnt;
   logic [3:0]  cnt_n;
   logic        accept;
   logic        commit;

   logic        req_write;
   logic        req_signext;
   logic        req_misalign;
   logic [1:0]  req_size;
   logic [AW-1:0] req_addr;
   logic [31:0] req_wdata;

   logic        misalign_in;
   logic [AW-1:0] a1;
   logic [AW-1:0] a2;
   logic [AW-1:0] a3;
   logic [7:0]  b0;
   logic [7:0]  b1;
   logic [7:0]  b2;
   logic [7:0]  b3;
   logic [31:0] load_val;

   logic [7:0]  mem [DEPTH_BYTES];

   // Address bits above the RAM index only matter for wrap-around, i.e. not at all.
   logic        addr_unused;
   assign addr_unused = ^Address[31:AW];

   always_comb begin
      misalign_in = 1'b0;
      unique case (Size)
         2'b00:   misalign_in = 1'b0;
         2'b01:   misalign_in = Address[0];
         default: misalign_in = |Address[1:0];
      endcase
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      accept  = 1'b0;
      commit  = 1'b0;
      unique case (state)
         IDLE: begin
            if (Start && (MemRead ^ MemWrite)) begin
               accept  = 1'b1;
               state_n = ACCESS;
               cnt_n   = 4'(WAIT_STATES);
            end
         end
         ACCESS: begin
            if (cnt != 4'd0) begin
               cnt_n = cnt - 4'd1;
            end else begin
               commit  = 1'b1;
               state_n = DONE;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Aligned accesses never straddle the end of the RAM, so plain AW-bit
   // addition gives the correct wrapped byte indices.
   always_comb begin
      a1 = req_addr + AW'(1);
      a2 = req_addr + AW'(2);
      a3 = req_addr + AW'(3);
      b0 = mem[req_addr];
      b1 = mem[a1];
      b2 = mem[a2];
      b3 = mem[a3];
      load_val = '0;
      unique case (req_size)
         2'b00:   load_val = {{24{req_signext & b0[7]}}, b0};
         2'b01:   load_val = {{16{req_signext & b1[7]}}, b1, b0};
         default: load_val = {b3, b2, b1, b0};
      endcase
   end

   always_ff @(posedge CLK or negedge nReset) begin
      if (!nReset) begin
         state        <= IDLE;
         cnt          <= '0;
         req_write    <= 1'b0;
         req_signext  <= 1'b0;
         req_misalign <= 1'b0;
         req_size     <= '0;
         req_addr     <= '0;
         req_wdata    <= '0;
         ReadData     <= '0;
         Busy         <= 1'b0;
         Done         <= 1'b0;
         AlignErr     <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         Busy     <= (state_n == ACCESS);
         Done     <= (state_n == DONE);
         // state_n is DONE only on the commit edge, so the latched fault applies.
         AlignErr <= (state_n == DONE) && req_misalign;
         if (accept) begin
            req_write    <= MemWrite;
            req_signext  <= SignExt;
            req_misalign <= misalign_in;
            req_size     <= Size;
            req_addr     <= Address[AW-1:0];
            req_wdata    <= WriteData;
         end
         if (commit && !req_write && !req_misalign) begin
            ReadData <= load_val;
         end
      end
   end

   // RAM is not reset; commit is derived from reset state, so an aborted access never writes.
   always_ff @(posedge CLK) begin
      if (commit && req_write && !req_misalign) begin
         mem[req_addr] <= req_wdata[7:0];
         if (req_size != 2'b00) begin
            mem[a1] <= req_wdata[15:8];
         end
         if (req_size[1]) begin
            mem[a2] <= req_wdata[23:16];
            mem[a3] <= req_wdata[31:24];
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Self-checking bench for mem_access_unit: directed scenarios plus random
//   accesses compared against a byte-array model of the RAM.
module tb_mem_access_unit;

   localparam int DEPTH = 256;
   localparam int WS    = 2;

   logic        CLK = 1'b0;
   logic        nReset;
   logic        Start;
   logic        MemRead;
   logic        MemWrite;
   logic [1:0]  Size;
   logic        SignExt;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Busy;
   logic        Done;
   logic        AlignErr;

   byte unsigned ref_mem [DEPTH];
   logic [31:0]  exp_rd;
   int           n_checks = 0;
   int           n_fail   = 0;

   mem_access_unit #(
      .DEPTH_BYTES(DEPTH),
      .WAIT_STATES(WS)
   ) dut (
      .CLK      (CLK),
      .nReset   (nReset),
      .Start    (Start),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .Size     (Size),
      .SignExt  (SignExt),
      .Address  (Address),
      .WriteData(WriteData),
      .ReadData (ReadData),
      .Busy     (Busy),
      .Done     (Done),
      .AlignErr (AlignErr)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit is_misaligned(input logic [1:0] sz, input logic [31:0] addr);
      return (addr % nbytes(sz)) != 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sext, input logic [31:0] addr);
      logic [31:0] v = 0;
      int n = nbytes(sz);
      for (int i = 0; i < n; i++)
         v = v | (32'(ref_mem[(addr + i) % DEPTH]) << (8 * i));
      if (n < 4 && sext && v[8*n-1])
         v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   task automatic model_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data);
      for (int i = 0; i < nbytes(sz); i++)
         ref_mem[(addr + i) % DEPTH] = 8'(data >> (8 * i));
   endtask

   // One complete access; with poke set, Start is held high with a different
   // store request for the whole busy period, which must be ignored.
   task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit sext,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit poke);
      int busy_cnt = 0;
      int cyc      = 0;
      bit seen     = 0;
      bit mis;
      @(negedge CLK);
      Start = 1'b1; MemRead = rd; MemWrite = wr; Size = sz; SignExt = sext;
      Address = addr; WriteData = wdata;
      @(posedge CLK);
      #1;
      if (poke) begin
         Start = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Size = 2'b10;
         Address = addr ^ 32'h40; WriteData = ~wdata;
      end else begin
         Start = 1'b0; MemRead = 1'($urandom); MemWrite = 1'($urandom);
         Size = 2'($urandom); SignExt = 1'($urandom);
         Address = $urandom; WriteData = $urandom;
      end
      mis = is_misaligned(sz, addr);
      if (!mis) begin
         if (wr) model_store(sz, addr, wdata);
         else    exp_rd = model_load(sz, sext, addr);
      end
      while (!seen && cyc < 40) begin
         @(negedge CLK);
         cyc++;
         check_eq("busy_done_excl", 32'(Busy & Done), 0);
         check_eq("align_qual", 32'(AlignErr & ~Done), 0);
         if (Done) seen = 1;
         else if (Busy) busy_cnt++;
      end
      check_eq("done_seen", 32'(seen), 1);
      check_eq("busy_cycles", busy_cnt, WS + 1);
      check_eq("align_err", 32'(AlignErr), 32'(mis));
      check_eq("read_data", ReadData, exp_rd);
      Start = 1'b0;
      @(negedge CLK);
      check_eq("done_one_cycle", 32'(Done), 0);
      check_eq("busy_after", 32'(Busy), 0);
   endtask

   task automatic ignored_req(input bit rd, input bit wr);
      @(negedge CLK);
      Start = 1'b1; MemRead = rd; MemWrite = wr; Size = 2'b10;
      Address = 32'h20; WriteData = 32'h5555_AAAA;
      repeat (6) begin
         @(negedge CLK);
         check_eq("ign_busy", 32'(Busy), 0);
         check_eq("ign_done", 32'(Done), 0);
      end
      Start = 1'b0;
      check_eq("ign_rdata", ReadData, exp_rd);
   endtask

   initial begin
      nReset = 1'b0; Start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      Size = 2'b00; SignExt = 1'b0; Address = '0; WriteData = '0;
      exp_rd = '0;
      repeat (3) @(negedge CLK);
      check_eq("rst_rdata", ReadData, 0);
      check_eq("rst_busy", 32'(Busy), 0);
      check_eq("rst_done", 32'(Done), 0);
      check_eq("rst_align", 32'(AlignErr), 0);
      nReset = 1'b1;

      // Fill the whole RAM so every later load has a defined expectation.
      for (int i = 0; i < DEPTH / 4; i++)
         access(0, 1, 2'b10, 0, 32'(i * 4), $urandom, 0);

      // Reset in the middle of a word store: outputs clear at once, no write.
      @(negedge CLK);
      Start = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Size = 2'b10;
      Address = 32'h10; WriteData = 32'hDEAD_BEEF;
      @(posedge CLK);
      #1 Start = 1'b0;
      @(negedge CLK);
      check_eq("pre_rst_busy", 32'(Busy), 1);
      #2 nReset = 1'b0;
      #1;
      check_eq("midrst_busy", 32'(Busy), 0);
      check_eq("midrst_done", 32'(Done), 0);
      check_eq("midrst_align", 32'(AlignErr), 0);
      check_eq("midrst_rdata", ReadData, 0);
      exp_rd = '0;
      repeat (2) @(negedge CLK);
      nReset = 1'b1;
      access(1, 0, 2'b10, 0, 32'h10, 0, 0);

      // Word round trip and little-endian byte order.
      access(0, 1, 2'b10, 0, 32'h20, 32'h1234_5678, 0);
      access(1, 0, 2'b10, 0, 32'h20, 0, 0);
      check_eq("word_rt", ReadData, 32'h1234_5678);
      access(1, 0, 2'b00, 0, 32'h20, 0, 0);
      check_eq("byte20", ReadData, 32'h78);
      access(1, 0, 2'b00, 0, 32'h21, 0, 0);
      check_eq("byte21", ReadData, 32'h56);
      access(1, 0, 2'b00, 0, 32'h22, 0, 0);
      check_eq("byte22", ReadData, 32'h34);
      access(1, 0, 2'b00, 0, 32'h23, 0, 0);
      check_eq("byte23", ReadData, 32'h12);

      // Narrow stores and extension.
      access(0, 1, 2'b00, 0, 32'h31, 32'hAAAA_AA80, 0);
      access(1, 0, 2'b00, 1, 32'h31, 0, 0);
      check_eq("sbyte", ReadData, 32'hFFFF_FF80);
      access(1, 0, 2'b00, 0, 32'h31, 0, 0);
      check_eq("ubyte", ReadData, 32'h0000_0080);
      access(0, 1, 2'b01, 0, 32'h32, 32'h0000_8001, 0);
      access(1, 0, 2'b01, 1, 32'h32, 0, 0);
      check_eq("shalf", ReadData, 32'hFFFF_8001);
      access(1, 0, 2'b11, 1, 32'h30, 0, 0);

      // Misaligned accesses: fault, no write, ReadData held.
      access(0, 1, 2'b10, 0, 32'h22, 32'hFFFF_FFFF, 0);
      access(1, 0, 2'b01, 0, 32'h21, 0, 0);
      access(1, 0, 2'b10, 0, 32'h20, 0, 0);
      check_eq("misalign_keep", ReadData, 32'h1234_5678);

      // Ignored requests.
      ignored_req(1, 1);
      ignored_req(0, 0);
      access(0, 1, 2'b10, 0, 32'h88, 32'h0BAD_F00D, 1);
      access(1, 0, 2'b10, 0, 32'h88, 0, 0);
      check_eq("poke_latched", ReadData, 32'h0BAD_F00D);
      access(1, 0, 2'b10, 0, 32'hC8, 0, 0);

      // Wrap-around.
      access(0, 1, 2'b10, 0, 32'h0000_0104, 32'hCAFE_F00D, 0);
      access(1, 0, 2'b10, 0, 32'h04, 0, 0);
      check_eq("wrap", ReadData, 32'hCAFE_F00D);

      // Random traffic.
      for (int i = 0; i < 250; i++) begin
         bit w = 1'($urandom);
         access(!w, w, 2'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom_range(0, 7) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
